// File: rtl/lfsr_checker.sv
// Receive-side checker for an 8-bit LFSR stream with taps 8,6,5,4.
// It seeds itself from the stream, locks after enough correct predictions, then counts mismatches.
module lfsr_checker #(
  parameter int unsigned SYNC_MATCHES = 2,
  parameter int unsigned LOCK_ERRS    = 3,
  parameter int unsigned ERR_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SYNC_W = (SYNC_MATCHES > 1) ? $clog2(SYNC_MATCHES) : 1;
  localparam int unsigned MISS_W = (LOCK_ERRS > 1) ? $clog2(LOCK_ERRS) : 1;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  exp_q;
  logic [SYNC_W-1:0]  sync_cnt_q;
  logic [MISS_W-1:0]  miss_cnt_q;
  logic               locked_q;
  logic               err_pulse_q;
  logic [ERR_W-1:0]   err_count_q;

  logic [DATA_W-1:0]  seed_exp_d;
  logic [DATA_W-1:0]  fly_exp_d;
  logic [ERR_W-1:0]   err_inc_d;
  logic               match_c;
  logic               zero_in_c;
  logic               sync_done_c;
  logic               miss_done_c;
  logic               lock_err_c;
  logic               err_sat_c;

  function automatic logic [DATA_W-1:0] lfsr_nxt(input logic [DATA_W-1:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Prediction candidates and beat classification.
  always_comb begin
    seed_exp_d  = lfsr_nxt(in_data);
    fly_exp_d   = lfsr_nxt(exp_q);
    match_c     = (in_data == exp_q);
    zero_in_c   = (in_data == '0);
    sync_done_c = ((32'(sync_cnt_q) + 32'd1) == SYNC_MATCHES);
    miss_done_c = ((32'(miss_cnt_q) + 32'd1) == LOCK_ERRS);
    lock_err_c  = in_valid && (state_q == ST_LOCKED) && !match_c;
    err_sat_c   = &err_count_q;
    err_inc_d   = err_count_q + ERR_W'(1);
  end

  // Lock FSM, predictor and error accounting; a locked checker flywheels and never reseeds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      exp_q       <= '0;
      sync_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= lock_err_c;

      // clear wins over a simultaneous error, which is then not counted
      if (clear) begin
        err_count_q <= '0;
      end else if (lock_err_c && !err_sat_c) begin
        err_count_q <= err_inc_d;
      end

      if (in_valid) begin
        case (state_q)
          ST_HUNT: begin
            if (!zero_in_c) begin
              exp_q      <= seed_exp_d;
              sync_cnt_q <= '0;
              state_q    <= ST_SYNC;
            end
          end

          ST_SYNC: begin
            exp_q <= seed_exp_d;
            if (match_c) begin
              if (sync_done_c) begin
                state_q    <= ST_LOCKED;
                locked_q   <= 1'b1;
                miss_cnt_q <= '0;
                sync_cnt_q <= '0;
              end else begin
                sync_cnt_q <= sync_cnt_q + SYNC_W'(1);
              end
            end else begin
              sync_cnt_q <= '0;
              if (zero_in_c) begin
                state_q <= ST_HUNT;
              end
            end
          end

          ST_LOCKED: begin
            exp_q <= fly_exp_d;
            if (match_c) begin
              miss_cnt_q <= '0;
            end else if (miss_done_c) begin
              state_q    <= ST_HUNT;
              locked_q   <= 1'b0;
              miss_cnt_q <= '0;
            end else begin
              miss_cnt_q <= miss_cnt_q + MISS_W'(1);
            end
          end

          default: begin
            state_q  <= ST_HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a default instance and a narrow-counter instance share stimulus,
// each compared every cycle against a behavioural model plus hand-computed literal checks.
module tb_lfsr_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       clear;

  logic       locked_a, err_pulse_a;
  logic [7:0] err_count_a;
  logic       locked_b, err_pulse_b;
  logic [1:0] err_count_b;

  int total = 0;
  int bad   = 0;

  lfsr_checker u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a)
  );

  lfsr_checker #(.SYNC_MATCHES(2), .LOCK_ERRS(8), .ERR_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: shift left, feed back the parity of taps 8,6,5,4 (mask 0xB8).
  function automatic int nxt(input int x);
    logic [7:0] v;
    v = 8'(x);
    return ((x * 2) % 256) + int'(^(v & 8'hB8));
  endfunction

  int  p_sync [2] = '{2, 2};
  int  p_lock [2] = '{3, 8};
  int  p_max  [2] = '{255, 3};
  int  m_mode [2];  // 0 hunting, 1 syncing, 2 locked
  int  m_exp  [2];
  int  m_sync [2];
  int  m_miss [2];
  int  m_cnt  [2];
  bit  m_lock [2];
  bit  m_pulse[2];
  bit  model_on = 1'b0;

  always @(posedge clk) begin
    bit e;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_mode[k] = 0; m_exp[k] = 0; m_sync[k] = 0; m_miss[k] = 0;
        m_cnt[k] = 0; m_lock[k] = 1'b0; m_pulse[k] = 1'b0;
      end else begin
        e = 1'b0;
        if (in_valid) begin
          if (m_mode[k] == 2) begin
            e = (int'(in_data) != m_exp[k]);
            m_exp[k] = nxt(m_exp[k]);
            m_miss[k] = e ? m_miss[k] + 1 : 0;
            if (m_miss[k] == p_lock[k]) begin
              m_mode[k] = 0;
              m_miss[k] = 0;
            end
          end else if (m_mode[k] == 1 && int'(in_data) == m_exp[k]) begin
            m_sync[k]++;
            m_exp[k] = nxt(m_exp[k]);
            if (m_sync[k] == p_sync[k]) begin
              m_mode[k] = 2;
              m_miss[k] = 0;
            end
          end else if (in_data != 8'h00) begin
            m_mode[k] = 1;
            m_sync[k] = 0;
            m_exp[k]  = nxt(int'(in_data));
          end else begin
            m_mode[k] = 0;
          end
        end
        m_pulse[k] = e;
        if (clear)        m_cnt[k] = 0;
        else if (e)       m_cnt[k] = (m_cnt[k] < p_max[k]) ? m_cnt[k] + 1 : p_max[k];
        m_lock[k] = (m_mode[k] == 2);
      end
    end
    model_on = 1'b1;
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("model_a_locked", int'(locked_a), int'(m_lock[0]));
      chk("model_a_pulse",  int'(err_pulse_a), int'(m_pulse[0]));
      chk("model_a_count",  int'(err_count_a), m_cnt[0]);
      chk("model_b_locked", int'(locked_b), int'(m_lock[1]));
      chk("model_b_pulse",  int'(err_pulse_b), int'(m_pulse[1]));
      chk("model_b_count",  int'(err_count_b), m_cnt[1]);
    end
  end

  // Drive one cycle of inputs, then return at the next falling edge with outputs updated.
  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit c);
    rst = r; in_valid = v; in_data = d; clear = c;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clear = 1'b0;

    // T1: reset with valid beats present
    step(1, 1, 8'h01, 0);
    step(1, 1, 8'h02, 1);
    chk("t1_locked", int'(locked_a), 0);
    chk("t1_pulse",  int'(err_pulse_a), 0);
    chk("t1_count",  int'(err_count_a), 0);
    chk("t1_b_count", int'(err_count_b), 0);

    // T2: acquire on back-to-back beats
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 0);
    chk("t2_not_yet", int'(locked_a), 0);
    step(0, 1, 8'h04, 0);
    chk("t2_locked", int'(locked_a), 1);
    chk("t2_count",  int'(err_count_a), 0);

    // T2 with idle gaps between beats
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h01, 0);
    step(0, 0, 8'h55, 0);
    step(0, 1, 8'h02, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'hAA, 0);
    chk("t2i_not_yet", int'(locked_a), 0);
    step(0, 1, 8'h04, 0);
    chk("t2i_locked", int'(locked_a), 1);

    // T3: single error, then flywheel match on 0x11
    step(0, 1, 8'h09, 0);
    chk("t3_pulse",  int'(err_pulse_a), 1);
    chk("t3_count",  int'(err_count_a), 1);
    chk("t3_locked", int'(locked_a), 1);
    step(0, 1, 8'h11, 0);
    chk("t3_nopulse", int'(err_pulse_a), 0);
    chk("t3_count2",  int'(err_count_a), 1);
    chk("t3_locked2", int'(locked_a), 1);

    step(0, 0, 8'h00, 1);
    chk("clr_count", int'(err_count_a), 0);

    // T4: lock loss after three consecutive misses
    step(0, 1, 8'hFF, 0);
    chk("t4_p1", int'(err_pulse_a), 1);
    chk("t4_c1", int'(err_count_a), 1);
    step(0, 1, 8'hFF, 0);
    chk("t4_p2", int'(err_pulse_a), 1);
    chk("t4_l2", int'(locked_a), 1);
    step(0, 1, 8'hFF, 0);
    chk("t4_p3", int'(err_pulse_a), 1);
    chk("t4_c3", int'(err_count_a), 3);
    chk("t4_l3", int'(locked_a), 0);
    chk("t4_b_still_locked", int'(locked_b), 1);
    step(0, 1, 8'h23, 0);
    chk("t4_hunt_p", int'(err_pulse_a), 0);
    step(0, 1, 8'h47, 0);
    chk("t4_sync_p", int'(err_pulse_a), 0);
    chk("t4_sync_l", int'(locked_a), 0);
    chk("t4_keep_c", int'(err_count_a), 3);

    // T5: zero is never a seed, and zero during sync returns to hunt
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);
    chk("t5_zero_l", int'(locked_a), 0);
    chk("t5_zero_p", int'(err_pulse_a), 0);
    step(0, 1, 8'h05, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    chk("t5_back_hunt", int'(locked_a), 0);
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 0);
    chk("t5_reacq_no", int'(locked_a), 0);
    step(0, 1, 8'h04, 0);
    chk("t5_reacq", int'(locked_a), 1);

    // T6: 2-bit counter saturates; clear beats a simultaneous error
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 0);
    step(0, 1, 8'h04, 0);
    chk("t6_locked", int'(locked_b), 1);
    step(0, 1, 8'hFF, 0);
    step(0, 1, 8'hFF, 0);
    chk("t6_c2", int'(err_count_b), 2);
    step(0, 1, 8'hFF, 0);
    chk("t6_c3", int'(err_count_b), 3);
    step(0, 1, 8'hFF, 0);
    step(0, 1, 8'hFF, 0);
    chk("t6_sat",  int'(err_count_b), 3);
    chk("t6_lock", int'(locked_b), 1);
    chk("t6_pulse", int'(err_pulse_b), 1);
    step(0, 1, 8'hFF, 1);
    chk("t6_clr_c", int'(err_count_b), 0);
    chk("t6_clr_p", int'(err_pulse_b), 1);
    step(0, 0, 8'h00, 0);
    chk("t6_idle_p", int'(err_pulse_b), 0);

    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
